// File: rtl/mips_divider_pkg.sv
// Shared constants and helpers for the multi-cycle MIPS DIV/DIVU unit.
package mips_divider_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int DIV_STEPS = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;

  function automatic logic [31:0] negate32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/mips_divider_if.sv
// Request/result bundle between the core (master) and the divider (slave).
interface mips_divider_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/subtract_32_bit.sv
// 32-bit subtractor: diff = a - b, cout = 1 when no borrow (a >= b unsigned).
// Purely combinational, no flow control.
module subtract_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        cout
);
  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + 33'd1;
endmodule

// File: rtl/mips_divider.sv
// Restoring divider for DIV/DIVU producing LO (quotient) and HI (remainder).
// Latency 33 cycles from accepted start to done; start is ignored while busy.
module mips_divider
  import mips_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mips_divider_if.slave div
);

  logic [1:0]       state;
  logic [WIDTH-1:0] q_reg, r_reg, dvs_mag, dvd_raw;
  logic [4:0]       count;
  logic             neg_q, neg_r, dbz_pend;
  logic             done_r, dbz_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag_in;
  logic [WIDTH-1:0] shifted, trial;
  logic             carry_bit, sub_cout, success;

  assign dvd_neg    = div.is_signed & div.dividend[WIDTH-1];
  assign dvs_neg    = div.is_signed & div.divisor[WIDTH-1];
  assign dvd_mag    = dvd_neg ? negate32(div.dividend) : div.dividend;
  assign dvs_mag_in = dvs_neg ? negate32(div.divisor) : div.divisor;

  // Bit shifted out of R acts as a 33rd bit: if set, the trial always fits.
  assign shifted   = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign carry_bit = r_reg[WIDTH-1];
  assign success   = carry_bit | sub_cout;

  subtract_32_bit u_sub (
    .a    (shifted),
    .b    (dvs_mag),
    .diff (trial),
    .cout (sub_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_reg       <= '0;
      r_reg       <= '0;
      dvs_mag     <= '0;
      dvd_raw     <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_pend    <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (div.start) begin
            dvd_raw  <= div.dividend;
            dvs_mag  <= dvs_mag_in;
            q_reg    <= dvd_mag;
            r_reg    <= '0;
            count    <= '0;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            dbz_pend <= (div.divisor == '0);
            state    <= ITER;
          end
        end
        ITER: begin
          r_reg <= success ? trial : shifted;
          q_reg <= {q_reg[WIDTH-2:0], success};
          count <= count + 5'd1;
          if (count == 5'(DIV_STEPS - 1)) state <= FIX;
        end
        FIX: begin
          if (dbz_pend) begin
            quotient_r  <= DIV_BY_ZERO_Q;
            remainder_r <= dvd_raw;
          end else begin
            quotient_r  <= neg_q ? negate32(q_reg) : q_reg;
            remainder_r <= neg_r ? negate32(r_reg) : r_reg;
          end
          dbz_r  <= dbz_pend;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div.busy        = (state != IDLE);
  assign div.done        = done_r;
  assign div.quotient    = quotient_r;
  assign div.remainder   = remainder_r;
  assign div.div_by_zero = dbz_r;

endmodule
